// File: rtl/i2c_slave_regs_pkg.sv
// I2C slave register-file definitions shared by the slave and the I2C master
// blocks: FSM state encodings, the reserved/default bus addresses and the
// address-match helper.
package i2c_slave_regs_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_PTR      = 4'd3,
    ST_PTR_ACK  = 4'd4,
    ST_WR_DATA  = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD_DATA  = 4'd7,
    ST_RD_ACK   = 4'd8,
    ST_IGNORE   = 4'd9
  } state_t;

  // Address 0 is the general call; a slave strapped to 0 never responds.
  localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;
  localparam logic [6:0] DEFAULT_DEV_ADDR  = 7'h42;

  function automatic logic addr_match(input logic [6:0] rx_addr,
                                      input logic [6:0] own_addr);
    return (own_addr != GENERAL_CALL_ADDR) && (rx_addr == own_addr);
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Pad-line conditioner for one I2C wire: 2-flop synchronizer followed by a
// glitch filter that only accepts a new level after FILTER_LEN consecutive
// equal samples. Pin-to-output latency is 2+FILTER_LEN cycles.
// Ports:
//   clk_sys  - system clock
//   rst      - synchronous active-high reset (all stages load 1 = bus idle)
//   line_in  - raw asynchronous pad level
//   line_out - synchronized, filtered level
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic line_in,
  output logic line_out
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(FILTER_LEN - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Down-counter reloads whenever the sample agrees with the output; the
  // level flips when a disagreeing sample arrives at terminal count.
  always_comb begin
    sync1_d = line_in;
    sync2_d = sync1_q;
    out_d   = out_q;
    cnt_d   = RELOAD;
    if (sync2_q != out_q) begin
      if (cnt_q == '0) begin
        out_d = sync2_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      out_q   <= 1'b1;
      cnt_q   <= RELOAD;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign line_out = out_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing NUM_REGS 8-bit registers. A write sets the register
// pointer from the first data byte and then fills registers with
// auto-increment; a read streams registers from the pointer with
// auto-increment. No clock stretching; SCL is never driven.
// Ports:
//   CLK, RST   - system clock, synchronous active-high reset
//   SCL_IN     - raw SCL pad level
//   SDA_IN     - raw SDA pad level
//   SDA_OE     - 1 pulls SDA low
//   DEV_ADDR   - own 7-bit address (0 disables the slave)
//   REGS       - flat register file, register i at [8i+7:8i]
//   WR_STROBE  - one-cycle pulse per register byte written
//   WR_PTR     - register index belonging to WR_STROBE
//   BUSY       - address-matched START seen, no STOP yet
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | bus free or not addressed, waiting for START
// ADDR       | shifting in address + R/W
// ADDR_ACK   | driving ACK for own address
// PTR        | shifting in register pointer byte
// PTR_ACK    | driving ACK for pointer byte
// WR_DATA    | shifting in a register data byte
// WR_ACK     | driving ACK for a data byte
// RD_DATA    | shifting out REGS[pointer], MSB first
// RD_ACK     | SDA released, sampling master ACK/NACK
// IGNORE     | not for us / read ended, SDA released until START/STOP
module i2c_slave_regs
  import i2c_slave_regs_pkg::*;
#(
  parameter int NUM_REGS   = 8,
  parameter int FILTER_LEN = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SCL_IN,
  input  logic                  SDA_IN,
  output logic                  SDA_OE,
  input  logic [6:0]            DEV_ADDR,
  output logic [8*NUM_REGS-1:0] REGS,
  output logic                  WR_STROBE,
  output logic [2:0]            WR_PTR,
  output logic                  BUSY
);

  localparam logic [2:0] PTR_MASK = 3'(NUM_REGS - 1);

  logic scl_f, sda_f;
  logic scl_prev_q, scl_prev_d;
  logic sda_prev_q, sda_prev_d;
  logic start_det, stop_det, scl_rise, scl_fall;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic [2:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  logic [7:0] rx_byte;
  logic [2:0] ptr_inc;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk_sys  (CLK),
    .rst      (RST),
    .line_in  (SCL_IN),
    .line_out (scl_f)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk_sys  (CLK),
    .rst      (RST),
    .line_in  (SDA_IN),
    .line_out (sda_f)
  );

  always_comb begin
    scl_prev_d = scl_f;
    sda_prev_d = sda_f;
    start_det  = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    stop_det   = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
    scl_rise   = scl_f & ~scl_prev_q;
    scl_fall   = ~scl_f & scl_prev_q;
    rx_byte    = {shift_q[6:0], sda_f};
    ptr_inc    = (ptr_q + 3'd1) & PTR_MASK;
  end

  // ACK states use sda_oe_q as their phase bit: the first SCL fall (end of
  // bit 0) starts driving ACK, the second fall (end of the ACK clock) ends it.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    regs_d      = regs_q;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rw_d = sda_f;
              if (addr_match(shift_q[6:0], DEV_ADDR)) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              bit_cnt_d = 3'd0;
              if (rw_q) begin
                state_d  = ST_RD_DATA;
                shift_d  = regs_q[ptr_q];
                sda_oe_d = ~regs_q[ptr_q][7];
              end else begin
                state_d  = ST_PTR;
                sda_oe_d = 1'b0;
              end
            end
          end
        end

        ST_PTR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_d   = rx_byte[2:0] & PTR_MASK;
              state_d = ST_PTR_ACK;
            end
          end
        end

        ST_PTR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = ST_WR_DATA;
            end
          end
        end

        ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              regs_d[ptr_q] = rx_byte;
              wr_strobe_d   = 1'b1;
              wr_ptr_d      = ptr_q;
              ptr_d         = ptr_inc;
              state_d       = ST_WR_ACK;
            end
          end
        end

        ST_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_RD_ACK;
            end
          end else if (scl_fall) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end

        // bit_cnt_q flags whether the master's ACK bit has been sampled yet;
        // the sampled level is parked in shift_q[0].
        ST_RD_ACK: begin
          if (scl_rise) begin
            bit_cnt_d  = 3'd1;
            shift_d[0] = sda_f;
          end else if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
            end else if (!shift_q[0]) begin
              ptr_d     = ptr_inc;
              bit_cnt_d = 3'd0;
              shift_d   = regs_q[ptr_inc];
              sda_oe_d  = ~regs_q[ptr_inc][7];
              state_d   = ST_RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_IGNORE;
            end
          end
        end

        ST_IGNORE: sda_oe_d = 1'b0;

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      rw_q        <= 1'b0;
      ptr_q       <= 3'd0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_ptr_q    <= 3'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      scl_prev_q  <= scl_prev_d;
      sda_prev_q  <= sda_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_ptr_q    <= wr_ptr_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign REGS[8*g +: 8] = regs_q[g];
  end

  assign SDA_OE    = sda_oe_q;
  assign BUSY      = busy_q;
  assign WR_STROBE = wr_strobe_q;
  assign WR_PTR    = wr_ptr_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
module tb_i2c_slave_regs;
  import i2c_slave_regs_pkg::*;

  localparam int NUM_REGS   = 8;
  localparam int FILTER_LEN = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        scl_drv = 1'b1;
  logic        sda_drv = 1'b1;
  logic        SDA_OE, WR_STROBE, BUSY;
  logic [2:0]  WR_PTR;
  logic [63:0] REGS;
  logic [6:0]  DEV_ADDR = DEFAULT_DEV_ADDR;
  logic        sda_line;

  assign sda_line = sda_drv & ~SDA_OE;

  always #10 CLK = ~CLK;

  i2c_slave_regs #(.NUM_REGS(NUM_REGS), .FILTER_LEN(FILTER_LEN)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SCL_IN    (scl_drv),
    .SDA_IN    (sda_line),
    .SDA_OE    (SDA_OE),
    .DEV_ADDR  (DEV_ADDR),
    .REGS      (REGS),
    .WR_STROBE (WR_STROBE),
    .WR_PTR    (WR_PTR),
    .BUSY      (BUSY)
  );

  int checks = 0;
  int errors = 0;
  int qtr    = 10;
  logic oe_seen = 1'b0;
  logic [7:0] model [8];

  typedef struct packed {
    logic [2:0] ptr;
    logic [7:0] data;
  } wr_exp_t;
  wr_exp_t    wr_q [$];
  logic [7:0] rd_q [$];

  typedef struct {
    logic [7:0] ptr_byte;
    logic [7:0] data;
    int         idx;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] flat_model();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = model[i];
    return r;
  endfunction

  task automatic wclk(input int n);
    repeat (n) @(posedge CLK);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; wclk(qtr);
    scl_drv = 1'b1; wclk(qtr);
    sda_drv = 1'b0; wclk(qtr);
    scl_drv = 1'b0; wclk(qtr);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wclk(qtr);
    scl_drv = 1'b1; wclk(qtr);
    sda_drv = 1'b1; wclk(qtr);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    sda_drv = b;    wclk(qtr);
    scl_drv = 1'b1; wclk(qtr);
    if (glitch) begin
      scl_drv = 1'b0; wclk(2);
      scl_drv = 1'b1;
    end
    wclk(qtr);
    scl_drv = 1'b0; wclk(qtr);
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_bit);
    sda_drv = 1'b1; wclk(qtr);
    scl_drv = 1'b1; wclk(qtr);
    ack = ~sda_line; wclk(qtr);
    scl_drv = 1'b0; wclk(qtr);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = 1'b1; wclk(qtr);
      scl_drv = 1'b1; wclk(qtr);
      b[i] = sda_line; wclk(qtr);
      scl_drv = 1'b0; wclk(qtr);
    end
    sda_drv = ~mack; wclk(qtr);
    scl_drv = 1'b1;  wclk(2*qtr);
    scl_drv = 1'b0;  wclk(qtr);
  endtask

  always @(negedge CLK) begin
    if (SDA_OE) oe_seen = 1'b1;
    if (!RST && WR_STROBE) begin
      if (wr_q.size() == 0) begin
        chk("wr_strobe_unexpected", {63'd0, WR_STROBE}, 64'd0);
      end else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        chk("wr_ptr", {61'd0, WR_PTR}, {61'd0, e.ptr});
        chk("wr_data", {56'd0, REGS[8*WR_PTR +: 8]}, {56'd0, e.data});
      end
    end
  end

  initial begin
    logic       ack;
    logic [7:0] d;

    vecs[0] = '{8'h00, 8'h11, 0};
    vecs[1] = '{8'h07, 8'h77, 7};
    vecs[2] = '{8'h0B, 8'h3C, 3};
    vecs[3] = '{8'h05, 8'hC3, 5};
    vecs[4] = '{8'hFE, 8'h80, 6};
    for (int i = 0; i < 8; i++) model[i] = 8'h00;

    wclk(5);
    @(negedge CLK) RST = 1'b0;
    @(negedge CLK);
    chk("rst_sda_oe", {63'd0, SDA_OE}, 64'd0);
    chk("rst_busy", {63'd0, BUSY}, 64'd0);
    chk("rst_wr_strobe", {63'd0, WR_STROBE}, 64'd0);
    chk("rst_wr_ptr", {61'd0, WR_PTR}, 64'd0);
    chk("rst_regs", REGS, 64'd0);

    // 100 kHz write burst: pointer 2, then A5 / 5A
    qtr = 125;
    wr_q.push_back('{3'd2, 8'hA5});
    wr_q.push_back('{3'd3, 8'h5A});
    i2c_start();
    write_byte(8'h84, -1, ack); chk("burst_addr_ack", {63'd0, ack}, 64'd1);
    chk("burst_busy", {63'd0, BUSY}, 64'd1);
    write_byte(8'h02, -1, ack); chk("burst_ptr_ack", {63'd0, ack}, 64'd1);
    write_byte(8'hA5, -1, ack); chk("burst_d0_ack", {63'd0, ack}, 64'd1);
    write_byte(8'h5A, -1, ack); chk("burst_d1_ack", {63'd0, ack}, 64'd1);
    i2c_stop();
    wclk(10);
    model[2] = 8'hA5;
    model[3] = 8'h5A;
    chk("burst_reg2", {56'd0, REGS[23:16]}, 64'hA5);
    chk("burst_reg3", {56'd0, REGS[31:24]}, 64'h5A);
    chk("burst_busy_after_stop", {63'd0, BUSY}, 64'd0);

    // single-byte writes, pointer taken mod NUM_REGS
    qtr = 10;
    for (int v = 0; v < 5; v++) begin
      wr_q.push_back('{3'(vecs[v].idx), vecs[v].data});
      i2c_start();
      write_byte(8'h84, -1, ack);          chk("vec_addr_ack", {63'd0, ack}, 64'd1);
      write_byte(vecs[v].ptr_byte, -1, ack); chk("vec_ptr_ack", {63'd0, ack}, 64'd1);
      write_byte(vecs[v].data, -1, ack);    chk("vec_data_ack", {63'd0, ack}, 64'd1);
      i2c_stop();
      wclk(5);
      model[vecs[v].idx] = vecs[v].data;
      chk("vec_regs", REGS, flat_model());
    end

    // pointer 7, repeated start, read two bytes with wrap, ACK then NACK
    i2c_start();
    write_byte(8'h84, -1, ack); chk("rd_waddr_ack", {63'd0, ack}, 64'd1);
    write_byte(8'h07, -1, ack); chk("rd_ptr_ack", {63'd0, ack}, 64'd1);
    i2c_start();
    write_byte(8'h85, -1, ack); chk("rd_raddr_ack", {63'd0, ack}, 64'd1);
    rd_q.push_back(8'h77);
    rd_q.push_back(8'h11);
    read_byte(1'b1, d); chk("rd_byte0", {56'd0, d}, {56'd0, rd_q.pop_front()});
    read_byte(1'b0, d); chk("rd_byte1", {56'd0, d}, {56'd0, rd_q.pop_front()});
    wclk(2);
    chk("rd_released_after_nack", {63'd0, SDA_OE}, 64'd0);
    i2c_stop();
    wclk(10);
    chk("rd_busy_after_stop", {63'd0, BUSY}, 64'd0);
    chk("rd_regs_unchanged", REGS, flat_model());

    // foreign address, then own address strapped to 0
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h86, -1, ack); chk("nomatch_ack", {63'd0, ack}, 64'd0);
    chk("nomatch_busy", {63'd0, BUSY}, 64'd0);
    write_byte(8'h55, -1, ack); chk("nomatch_data_ack", {63'd0, ack}, 64'd0);
    i2c_stop();
    DEV_ADDR = 7'h00;
    i2c_start();
    write_byte(8'h00, -1, ack); chk("addr0_ack", {63'd0, ack}, 64'd0);
    i2c_stop();
    DEV_ADDR = DEFAULT_DEV_ADDR;
    wclk(10);
    chk("nomatch_oe_never", {63'd0, oe_seen}, 64'd0);
    chk("nomatch_regs", REGS, flat_model());
    chk("nomatch_busy_end", {63'd0, BUSY}, 64'd0);

    // 2-cycle SCL low glitch inside a data byte
    wr_q.push_back('{3'd4, 8'hB6});
    i2c_start();
    write_byte(8'h84, -1, ack); chk("glitch_addr_ack", {63'd0, ack}, 64'd1);
    write_byte(8'h04, -1, ack); chk("glitch_ptr_ack", {63'd0, ack}, 64'd1);
    write_byte(8'hB6, 3, ack);  chk("glitch_data_ack", {63'd0, ack}, 64'd1);
    i2c_stop();
    wclk(5);
    model[4] = 8'hB6;
    chk("glitch_regs", REGS, flat_model());

    // reset while slave drives a 0 read bit (reg3 = 3C)
    i2c_start();
    write_byte(8'h84, -1, ack); chk("rst_rd_waddr_ack", {63'd0, ack}, 64'd1);
    write_byte(8'h03, -1, ack); chk("rst_rd_ptr_ack", {63'd0, ack}, 64'd1);
    i2c_start();
    write_byte(8'h85, -1, ack); chk("rst_rd_raddr_ack", {63'd0, ack}, 64'd1);
    for (int i = 0; i < 50 && !SDA_OE; i++) @(negedge CLK);
    chk("rst_rd_bit_driven", {63'd0, SDA_OE}, 64'd1);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("midrst_sda_oe", {63'd0, SDA_OE}, 64'd0);
    chk("midrst_regs", REGS, 64'd0);
    @(negedge CLK) RST = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    i2c_stop();
    wclk(10);

    // STOP after 4 bits of a data byte: no write, bus recovers
    i2c_start();
    write_byte(8'h84, -1, ack); chk("part_addr_ack", {63'd0, ack}, 64'd1);
    write_byte(8'h01, -1, ack); chk("part_ptr_ack", {63'd0, ack}, 64'd1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    i2c_stop();
    wclk(10);
    chk("part_busy", {63'd0, BUSY}, 64'd0);
    chk("part_sda_oe", {63'd0, SDA_OE}, 64'd0);
    chk("part_regs", REGS, flat_model());
    wr_q.push_back('{3'd1, 8'h99});
    i2c_start();
    write_byte(8'h84, -1, ack); chk("recover_addr_ack", {63'd0, ack}, 64'd1);
    write_byte(8'h01, -1, ack); chk("recover_ptr_ack", {63'd0, ack}, 64'd1);
    write_byte(8'h99, -1, ack); chk("recover_data_ack", {63'd0, ack}, 64'd1);
    i2c_stop();
    wclk(10);
    model[1] = 8'h99;
    chk("recover_regs", REGS, flat_model());

    chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
